// File: rtl/mem_pkg.sv
// Shared encodings for the MOV/MOC memory access initiator:
// access opcodes, size codes and the 2-bit FSM state.
package mem_pkg;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  function automatic logic [5:0] op_code(
    input logic       we,
    input logic [1:0] size
  );
    logic [5:0] op;
    op = we ? OP_SB : OP_LB;
    unique case (size)
      SZ_HALF: op = we ? OP_SH : OP_LH;
      SZ_WORD: op = we ? OP_SW : OP_LW;
      default: op = we ? OP_SB : OP_LB;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Combinational load extender: right-aligned byte/halfword/word
// data, optionally sign-extended to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  always_comb begin
    q_o = d_i;
    unique case (size_i)
      SZ_BYTE: q_o = {{24{sext_i & d_i[7]}}, d_i[7:0]};
      SZ_HALF: q_o = {{16{sext_i & d_i[15]}}, d_i[15:0]};
      default: q_o = d_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MOV/MOC memory access initiator: IDLE/ISSUE/WAIT/DONE handshake.
// Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 32
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_din,
  output logic [5:0]        mem_op,
  input  logic [31:0]       mem_dout,
  input  logic              mem_moc
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       ext;
  logic              bad_req;
  logic              on_bus;

  load_extend u_ext (
    .size_i (size_q),
    .sext_i (sext_q),
    .d_i    (mem_dout),
    .q_o    (ext)
  );

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    bad_req = 1'b0;
    unique case (1'b1)
      size == SZ_ILL:  bad_req = 1'b1;
      size == SZ_HALF: bad_req = addr[0];
      size == SZ_WORD: bad_req = |addr[1:0];
      default:         bad_req = 1'b0;
    endcase
  end
`else
  assign bad_req = (size == SZ_ILL);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sext;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          err_d   = bad_req;
          state_d = bad_req ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_moc) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = ext;
        end else if (TIMEOUT != 0 &&
                     cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs are pure functions of state so an abort drops MOV at once
  assign on_bus   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = done & err_q;
  assign rdata    = rdata_q;
  assign mem_mov  = on_bus;
  assign mem_rw   = on_bus ? ~we_q : 1'b1;
  assign mem_addr = on_bus ? 32'(addr_q) : 32'h0;
  assign mem_din  = on_bus ? wdata_q : 32'h0;
  assign mem_op   = on_bus ? op_code(we_q, size_q) : 6'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed plan steps plus
// randomized accesses against a behavioural handshake model.
module tb_mem_access_ctrl;

  localparam int TO = 15;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_mov, mem_rw;
  logic [31:0] mem_addr, mem_din;
  logic [5:0]  mem_op;
  logic [31:0] mem_dout = '0;
  logic        mem_moc = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd = '0;
  logic        align_en;

  mem_access_ctrl #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .Clk(Clk), .Clr(Clr), .req(req), .we(we), .size(size),
    .sext(sext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .mem_mov(mem_mov),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_op(mem_op), .mem_dout(mem_dout), .mem_moc(mem_moc)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_op(input logic w,
                                        input logic [1:0] sz);
    logic [5:0] op;
    case ({w, sz})
      3'b010:  op = 6'b100011;
      3'b001:  op = 6'b100001;
      3'b000:  op = 6'b100000;
      3'b110:  op = 6'b101011;
      3'b101:  op = 6'b101001;
      default: op = 6'b101000;
    endcase
    return op;
  endfunction

  // Extension computed arithmetically from the access width
  function automatic logic [31:0] exp_ext(input logic [1:0] sz,
                                          input logic sx,
                                          input logic [31:0] d);
    longint n, v;
    logic [63:0] r;
    if (sz == 2'b10) return d;
    n = (sz == 2'b00) ? 256 : 65536;
    v = longint'(d) % n;
    if (sx && v >= n / 2) v = v - n;
    r = 64'(v);
    return r[31:0];
  endfunction

  // Starts and ends at a negedge; lat = WAIT cycle in which MOC rises
  task automatic access(input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a,
                        input logic [31:0] wd, input int lat,
                        input logic [31:0] dout, input logic stale,
                        input logic hold);
    logic ill, mis, tmo;
    int   nw;
    mis = (sz == 2'b10 && a[1:0] != 2'b00) ||
          (sz == 2'b01 && a[0]);
    ill = (sz == 2'b11) || (align_en && mis);
    tmo = !ill && (lat > TO);
    nw  = tmo ? TO : lat;
    req = 1'b1; we = w; size = sz; sext = sx;
    addr = a; wdata = wd; mem_moc = stale; mem_dout = dout;
    @(negedge Clk);
    req = 1'b0;
    if (!ill) begin
      chk("issue_mov", 32'(mem_mov), 1);
      chk("issue_rw", 32'(mem_rw), 32'(!w));
      chk("issue_op", 32'(mem_op), 32'(exp_op(w, sz)));
      chk("issue_addr", mem_addr, a);
      chk("issue_din", mem_din, wd);
      chk("issue_done", 32'(done), 0);
      for (int k = 1; k <= nw; k++) begin
        @(negedge Clk);
        mem_moc = (k == lat);
        chk("wait_mov", 32'(mem_mov), 1);
        chk("wait_hold", {mem_addr[25:0], mem_op}, {a[25:0], exp_op(w, sz)});
        chk("wait_done", 32'(done), 0);
      end
      @(negedge Clk);
      mem_moc = 1'b0;
      if (!tmo && !w) exp_rd = exp_ext(sz, sx, dout);
    end
    chk("done", 32'(done), 1);
    chk("err", 32'(err), 32'(ill || tmo));
    chk("done_mov", 32'(mem_mov), 0);
    chk("rdata", rdata, exp_rd);
    if (hold) req = 1'b1;
    @(negedge Clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
  endtask

  initial begin
`ifdef MEM_ALIGN_CHECK_EN
    align_en = 1'b1;
`else
    align_en = 1'b0;
`endif
    repeat (2) @(negedge Clk);
    Clr = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mov", 32'(mem_mov), 0);
    chk("rst_rw", 32'(mem_rw), 1);
    chk("rst_bus", mem_addr | mem_din | 32'(mem_op), 0);
    @(negedge Clk);

    access(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, 0);
    access(0, 2'b10, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 0, 0);
    access(0, 2'b00, 1, 32'h20, 32'h0, 2, 32'h80, 0, 0);
    access(0, 2'b00, 0, 32'h20, 32'h0, 1, 32'h80, 0, 0);
    access(0, 2'b01, 1, 32'h22, 32'h0, 4, 32'h0000_9ABC, 1, 0);
    access(0, 2'b10, 0, 32'h30, 32'h0, TO + 5, 32'h1234_5678, 0, 0);
    access(1, 2'b11, 0, 32'h40, 32'h55, 1, 32'h0, 0, 0);
    access(0, 2'b10, 0, 32'h13, 32'h0, 1, 32'hCAFE_F00D, 0, 1);
    access(1, 2'b01, 0, 32'h44, 32'hBEEF, TO, 32'h0, 0, 0);

    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h40;
    @(negedge Clk);
    req = 1'b0;
    repeat (2) @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    exp_rd = '0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_mov", 32'(mem_mov), 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_done", 32'(done), 0);
    access(0, 2'b01, 0, 32'h50, 32'h0, 1, 32'h0000_8001, 0, 0);

    for (int i = 0; i < 30; i++) begin
      access($urandom_range(0, 1), 2'($urandom_range(0, 3)),
             $urandom_range(0, 1), $urandom, $urandom,
             $urandom_range(1, TO + 2), $urandom,
             $urandom_range(0, 1), (i < 29) && ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the MOV/MOC memory handshake: converts one load/store request from the control unit into a bus transaction toward ram512x8.
- Drives MOV, ReadWrite, the address, the write data and the 6-bit access opcode, then waits for MOC.
- Returns read data sign- or zero-extended, with a one-cycle done pulse.
- Sits between Control_Unit/MAR/MDR and the RAM; replaces ad-hoc MOV sequencing in control states.

Parameters:
- TIMEOUT, 15, max cycles in WAIT for MOC before err; 0 disables the timeout.
- ADDR_W, 32, address width.

Ports:
- Clk  in  1  clock; all state changes on rising edge.
- Clr  in  1  reset, synchronous, active-high.
- req  in  1  start request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 = byte, 01 = halfword, 10 = word; 11 is illegal.
- sext  in  1  sign-extend load result (byte/halfword only).
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on timeout/illegal/misaligned.
- rdata  out  32  load result; held until next load completes.
- mem_mov  out  1  MOV to memory.
- mem_rw  out  1  ReadWrite: 1 = read, 0 = write.
- mem_addr  out  32  Address to memory.
- mem_din  out  32  DataIn to memory.
- mem_op  out  6  OP to memory.
- mem_dout  in  32  DataOut from memory.
- mem_moc  in  1  MOC from memory.

Behaviour:
- Reset (Clr high at rising edge) forces IDLE. All outputs are 0, except mem_rw = 1 (idle reads are harmless). Reset mid-transaction aborts it: no done, mem_mov drops the next cycle, rdata clears.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req = 1, latch we/size/sext/addr/wdata and go to ISSUE.
  - A size = 11 request goes straight to DONE with err = 1 and no bus activity.
  - req is ignored while busy; there is no queueing.
- ISSUE:
  - mem_mov = 1; mem_rw = ~we; mem_addr and mem_din come from the latched values.
  - mem_op: load word 100011, load half 100001, load byte 100000, store word 101011, store half 101001, store byte 101000.
  - Always go to WAIT after one cycle. mem_moc is ignored in ISSUE because stale MOC from the previous access may still be high.
- WAIT:
  - Hold all mem_* outputs stable and count cycles.
  - mem_moc = 1 sampled: capture the result and go to DONE.
  - Count reaches TIMEOUT: go to DONE with err = 1; rdata is unchanged.
- DONE:
  - mem_mov = 0, done = 1 for exactly one cycle, then IDLE.
  - A req high during DONE is not accepted; it is sampled in the following IDLE cycle.
- Load extension (memory returns data right-aligned, big-endian):
  - byte: rdata = sext ? {24{d[7]}, d[7:0]} : {24'h0, d[7:0]}.
  - halfword: same rule using d[15:0].
  - word: rdata = d.
- Stores leave rdata unchanged.
- Minimum latency: req sampled at edge 0, mem_mov high in cycle 1, MOC sampled earliest at edge 2, done high in cycle 3. Back-to-back throughput is one access per 4 cycles.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, a halfword with addr[0] ≠ 0, or a word with addr[1:0] ≠ 0, goes to DONE with err = 1. mem_mov is never raised.
- Undefined: the address is passed through unchecked, matching current RAM behaviour.

Decomposition:
- Shared package mem_pkg holds:
  - the six opcode constants;
  - the size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state encoding (2-bit).
- One natural sub-module: load_extend, a combinational size/sext extender that is reusable in the datapath.

Test Plan:
- Word store then load: store addr = 0x10, wdata = 0xDEADBEEF, size = 10. Then load addr = 0x10, size = 10. Required: mem_op = 101011 then 100011; rdata = 0xDEADBEEF; done 3 cycles after each req.
- Byte sign-extension: memory byte at 0x20 = 0x80. Load size = 00, sext = 1 → rdata = 0xFFFFFF80. Load sext = 0 → rdata = 0x00000080.
- Halfword with stale MOC: hold mem_moc = 1 through ISSUE, then drop it and raise it 4 cycles later. Required: mem_mov high for 5 cycles; done only after the second MOC; rdata = the sign-extended 16-bit value.
- Timeout: mem_moc held at 0. Required: after 15 WAIT cycles, done = err = 1; rdata keeps its prior value; busy low the next cycle.
- Reset mid-WAIT: assert Clr for one edge. Required: next cycle busy = 0, mem_mov = 0, rdata = 0, no done. A new req is accepted immediately afterwards.
- With MEM_ALIGN_CHECK_EN: word load at addr = 0x13. Required: err = 1, done = 1, mem_mov stays 0 for the whole request.
